// File: rtl/c2f_burst_sink_pkg.sv
// Types local to the CPU->FPGA burst sink.
package c2f_burst_sink_pkg;
    // EMPTY: nothing held; PRIMING: RAM holds data, output register loads next edge; VALID: output holds a qword
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PRIMING = 2'd1,
        ST_VALID   = 2'd2
    } sink_state_e;
endpackage

// File: rtl/tlp_xcvr_pkg.sv
// Shared types and constants for the tlp_xcvr host link and its burst pipes.
package tlp_xcvr_pkg;
    typedef logic [63:0] uint64;
    localparam int unsigned C2F_BURST_QW = 8;
endpackage

// File: rtl/c2f_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module c2f_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register doubles as the sink's output register, so it is reset and held when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/c2f_burst_sink.sv
// Captures the no-backpressure c2f burst pipe into a circular buffer and replays it as a
// first-word-fall-through valid/ready stream with burst-consumed credit pulses.
module c2f_burst_sink
    import tlp_xcvr_pkg::*;
    import c2f_burst_sink_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned BURST_QW   = C2F_BURST_QW
) (
    input  logic                  clk_in,
    input  logic                  resetN_in,
    input  logic [63:0]           c2fData_in,
    input  logic                  c2fValid_in,
    output logic [63:0]           data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [DEPTH_LOG2:0]   level_out,
    output logic                  overflow_out,
    input  logic                  clearOverflow_in,
    output logic                  burstDone_out,
    output logic [31:0]           wordCount_out
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
    localparam int unsigned BCW   = (BURST_QW > 1) ? $clog2(BURST_QW) : 1;
    localparam int unsigned DATA_W = $bits(uint64);

    sink_state_e       state, state_nxt;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  ram_cnt;
    logic [BCW-1:0]    burst_cnt;

    logic hs_c, full_c, accept_c, rd_en_c, burst_last_c;

    c2f_ram #(
        .ADDR_W (PTR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk_in),
        .rst_n   (resetN_in),
        .wr_en   (accept_c),
        .wr_addr (wr_ptr),
        .wr_data (c2fData_in),
        .rd_en   (rd_en_c),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

    // Handshake/accept decode and prefetch state machine
    always_comb begin
        state_nxt    = state;
        hs_c         = valid_out & ready_in;
        full_c       = (level_out == LVL_W'(DEPTH));
        accept_c     = c2fValid_in & (~full_c | hs_c);
        rd_en_c      = (ram_cnt != '0) & (~valid_out | hs_c);
        burst_last_c = (burst_cnt == BCW'(BURST_QW - 1));

        case (state)
            ST_EMPTY: begin
                if (accept_c) begin
                    state_nxt = ST_PRIMING;
                end
            end
            ST_PRIMING: begin
                state_nxt = ST_VALID;
            end
            ST_VALID: begin
                // A write landing as the last word leaves needs one edge before it can be read
                if (hs_c && !rd_en_c) begin
                    state_nxt = accept_c ? ST_PRIMING : ST_EMPTY;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge resetN_in) begin
        if (!resetN_in) begin
            state         <= ST_EMPTY;
            valid_out     <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            ram_cnt       <= '0;
            level_out     <= '0;
            overflow_out  <= 1'b0;
            burst_cnt     <= '0;
            burstDone_out <= 1'b0;
            wordCount_out <= '0;
        end else begin
            state     <= state_nxt;
            valid_out <= (state_nxt == ST_VALID);

            if (accept_c) begin
                wr_ptr        <= wr_ptr + PTR_W'(1);
                wordCount_out <= wordCount_out + 32'd1;
            end
            if (rd_en_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            ram_cnt   <= ram_cnt + LVL_W'(accept_c) - LVL_W'(rd_en_c);
            level_out <= level_out + LVL_W'(accept_c) - LVL_W'(hs_c);

            // Set has priority over clear
            if (c2fValid_in && !accept_c) begin
                overflow_out <= 1'b1;
            end else if (clearOverflow_in) begin
                overflow_out <= 1'b0;
            end

            if (hs_c) begin
                burst_cnt <= burst_last_c ? '0 : burst_cnt + BCW'(1);
            end
            burstDone_out <= hs_c & burst_last_c;
        end
    end
endmodule

// File: tb/tb_c2f_burst_sink.sv
// Directed bench for c2f_burst_sink: vector table for a single burst, hand sequences for
// fill/overflow, streaming across wrap, and asynchronous reset.
module tb_c2f_burst_sink;
    logic        clk_in = 1'b0;
    logic        resetN_in;
    logic [63:0] c2fData_in;
    logic        c2fValid_in;
    logic [63:0] data_out;
    logic        valid_out;
    logic        ready_in;
    logic [6:0]  level_out;
    logic        overflow_out;
    logic        clearOverflow_in;
    logic        burstDone_out;
    logic [31:0] wordCount_out;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    c2f_burst_sink #(.DEPTH_LOG2(6), .BURST_QW(8)) dut (
        .clk_in           (clk_in),
        .resetN_in        (resetN_in),
        .c2fData_in       (c2fData_in),
        .c2fValid_in      (c2fValid_in),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .ready_in         (ready_in),
        .level_out        (level_out),
        .overflow_out     (overflow_out),
        .clearOverflow_in (clearOverflow_in),
        .burstDone_out    (burstDone_out),
        .wordCount_out    (wordCount_out)
    );

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        r;
        logic        clr;
        logic        ev;
        logic [63:0] ed;
        logic [6:0]  el;
        logic        eo;
        logic        eb;
        logic [31:0] ewc;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [63:0] seq64(input int i);
        return {32'hC2F0_0000 | 32'(i), 32'(i) ^ 32'h5A5A_5A5A};
    endfunction

    function automatic vec_t mk(input logic v, input logic [63:0] d, input logic r,
                                input logic clr, input logic ev, input logic [63:0] ed,
                                input logic [6:0] el, input logic eo, input logic eb,
                                input logic [31:0] ewc);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.clr = clr;
        t.ev = ev; t.ed = ed; t.el = el; t.eo = eo; t.eb = eb; t.ewc = ewc;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic r, input logic clr);
        c2fValid_in      = v;
        c2fData_in       = d;
        ready_in         = r;
        clearOverflow_in = clr;
    endtask

    task automatic do_reset();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        resetN_in = 1'b0;
        tick();
        tick();
        resetN_in = 1'b1;
    endtask

    logic [63:0] q [$];
    logic [63:0] exp_d;
    logic [63:0] hold_data;
    logic        hold, prev_bd, rr, vv;
    int          pushed, popped, pulses, idx;

    initial begin
        do_reset();
        check("reset valid", 64'(valid_out), 64'd0);
        check("reset data", data_out, 64'd0);
        check("reset level", 64'(level_out), 64'd0);
        check("reset overflow", 64'(overflow_out), 64'd0);
        check("reset burst", 64'(burstDone_out), 64'd0);
        check("reset count", 64'(wordCount_out), 64'd0);

        // One 8-qword burst streamed straight through
        vecs[0] = mk(1'b1, seq64(0), 1'b1, 1'b0, 1'b0, 64'd0, 7'd1, 1'b0, 1'b0, 32'd1);
        for (int k = 1; k < 8; k++)
            vecs[k] = mk(1'b1, seq64(k), 1'b1, 1'b0, 1'b1, seq64(k - 1), 7'd2, 1'b0, 1'b0, 32'(k + 1));
        vecs[8]  = mk(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, seq64(7), 7'd1, 1'b0, 1'b0, 32'd8);
        vecs[9]  = mk(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0,    7'd0, 1'b0, 1'b1, 32'd8);
        vecs[10] = mk(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0,    7'd0, 1'b0, 1'b0, 32'd8);
        for (int k = 0; k < 11; k++) begin
            drive(vecs[k].v, vecs[k].d, vecs[k].r, vecs[k].clr);
            tick();
            check($sformatf("vec%0d valid", k), 64'(valid_out), 64'(vecs[k].ev));
            if (vecs[k].ev) check($sformatf("vec%0d data", k), data_out, vecs[k].ed);
            check($sformatf("vec%0d level", k), 64'(level_out), 64'(vecs[k].el));
            check($sformatf("vec%0d overflow", k), 64'(overflow_out), 64'(vecs[k].eo));
            check($sformatf("vec%0d burst", k), 64'(burstDone_out), 64'(vecs[k].eb));
            check($sformatf("vec%0d count", k), 64'(wordCount_out), 64'(vecs[k].ewc));
        end

        // Fill to capacity, drop, overflow clear priority, full push+pop, drain
        do_reset();
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, seq64(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        check("full level", 64'(level_out), 64'd64);
        check("full overflow", 64'(overflow_out), 64'd0);
        check("full head", data_out, seq64(0));
        drive(1'b1, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 1'b0);
        tick();
        check("drop overflow", 64'(overflow_out), 64'd1);
        check("drop level", 64'(level_out), 64'd64);
        drive(1'b1, 64'hBAD1_BAD1_BAD1_BAD1, 1'b0, 1'b1);
        tick();
        check("set beats clear", 64'(overflow_out), 64'd1);
        drive(1'b0, 64'd0, 1'b0, 1'b1);
        tick();
        check("clear alone", 64'(overflow_out), 64'd0);
        drive(1'b1, seq64(64), 1'b1, 1'b0);
        tick();
        check("full swap level", 64'(level_out), 64'd64);
        check("full swap overflow", 64'(overflow_out), 64'd0);
        check("full swap head", data_out, seq64(1));
        check("full swap count", 64'(wordCount_out), 64'd65);
        drive(1'b0, 64'd0, 1'b1, 1'b0);
        idx = 1;
        for (int cyc = 0; cyc < 200 && idx <= 64; cyc++) begin
            if (valid_out) begin
                check($sformatf("drain %0d", idx), data_out, seq64(idx));
                idx++;
            end
            tick();
        end
        check("drain count", 64'(idx), 64'd65);
        check("drain level", 64'(level_out), 64'd0);
        check("drain valid", 64'(valid_out), 64'd0);

        // 200 qwords with random ready, across pointer wrap
        do_reset();
        q.delete();
        pushed = 0; popped = 0; pulses = 0; prev_bd = 1'b0;
        for (int cyc = 0; cyc < 3000 && popped < 200; cyc++) begin
            vv = (pushed < 200) && (q.size() < 60);
            rr = 1'($urandom_range(0, 1));
            drive(vv, seq64(1000 + pushed), rr, 1'b0);
            if (valid_out && rr) begin
                exp_d = q.pop_front();
                check($sformatf("stream %0d", popped), data_out, exp_d);
                popped++;
            end
            hold = valid_out & ~rr;
            hold_data = data_out;
            if (vv) begin
                q.push_back(seq64(1000 + pushed));
                pushed++;
            end
            tick();
            if (hold) begin
                check("hold valid", 64'(valid_out), 64'd1);
                check("hold data", data_out, hold_data);
            end
            check("stream level", 64'(level_out), 64'(q.size()));
            if (burstDone_out) begin
                pulses++;
                check("pulse isolated", 64'(prev_bd), 64'd0);
            end
            prev_bd = burstDone_out;
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        check("stream popped", 64'(popped), 64'd200);
        check("stream pulses", 64'(pulses), 64'd25);
        check("stream count", 64'(wordCount_out), 64'd200);

        // Asynchronous reset with 17 qwords held
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, seq64(300 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        check("pre-reset level", 64'(level_out), 64'd17);
        #2 resetN_in = 1'b0;
        #1;
        check("async valid", 64'(valid_out), 64'd0);
        check("async level", 64'(level_out), 64'd0);
        check("async count", 64'(wordCount_out), 64'd0);
        check("async burst", 64'(burstDone_out), 64'd0);
        #2 resetN_in = 1'b1;
        tick();
        drive(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        check("post-reset valid early", 64'(valid_out), 64'd0);
        tick();
        check("post-reset valid", 64'(valid_out), 64'd1);
        check("post-reset data", data_out, 64'h1234_5678_9ABC_DEF0);
        check("post-reset level", 64'(level_out), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
